// File: rtl/deserializer_pkg.sv
// Shared types and default sizes for the serial-to-parallel deserializer.
package deserializer_pkg;

  localparam int W_DATA   = 16;                  // parallel word width
  localparam int W_MOD    = $clog2(W_DATA);      // bit-count field; 0 encodes a full word
  localparam int MIN_BITS = 3;                   // shortest partial burst that is kept
  localparam int CNT_W    = $clog2(W_DATA + 1);  // bit counter must reach W_DATA

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/deserializer_if.sv
// Serial input stream and parallel output word of the deserializer.
//
// Handshake: ser_data is meaningful only in cycles where ser_data_val is 1;
// there is no backpressure, every valid bit is consumed on the rising edge.
// On the output side deser_data_val is a one-cycle pulse with no ready:
// deser_data / deser_data_mod must be taken in that cycle (they also hold
// their value afterwards until the next pulse). err is a one-cycle pulse
// reporting a dropped short burst.
interface deserializer_if;
  import deserializer_pkg::*;

  logic              ser_data;
  logic              ser_data_val;
  logic [W_DATA-1:0] deser_data;
  logic [W_MOD-1:0]  deser_data_mod;
  logic              deser_data_val;
  logic              deser_busy;
  logic              err;

  // Upstream side: drives the serial stream, observes the parallel result.
  modport master (
    output ser_data, ser_data_val,
    input  deser_data, deser_data_mod, deser_data_val, deser_busy, err
  );

  // Deserializer side.
  modport slave (
    input  ser_data, ser_data_val,
    output deser_data, deser_data_mod, deser_data_val, deser_busy, err
  );

endinterface

// File: rtl/deserializer.sv
// Rebuilds MSB-first serial bursts into left-aligned parallel words.
// Full words (W_DATA contiguous valid bits) are emitted with mod = 0; shorter
// bursts of at least MIN_BITS are emitted with their bit count; shorter ones
// are dropped with an err pulse.
module deserializer
  import deserializer_pkg::*;
(
  input  logic           clk_i,
  input  logic           srst_i,
  deserializer_if.slave  bus,
  output state_t         dbg_state_o
);

  state_t            state_q, state_d;
  logic [W_DATA-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W_DATA-1:0] data_q, data_d;
  logic [W_MOD-1:0]  mod_q, mod_d;
  logic              val_q, val_d;
  logic              err_q, err_d;

  // Write position of the incoming bit; W_DATA is a power of two, so the
  // counter's low W_MOD bits index the shift register directly.
  logic [W_MOD-1:0]  wr_idx;
  logic [W_DATA-1:0] word_in;

  // Next-state, shift register, counter and output-register computation.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    err_d   = 1'b0;

    wr_idx           = W_MOD'(W_DATA - 1) - cnt_q[W_MOD-1:0];
    word_in          = sh_q;
    word_in[wr_idx]  = bus.ser_data;

    case (state_q)
      IDLE: begin
        // sh_q and cnt_q are always zero here, so word_in holds just bit 0.
        if (bus.ser_data_val) begin
          sh_d    = word_in;
          cnt_d   = CNT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.ser_data_val) begin
          if (cnt_q == CNT_W'(W_DATA - 1)) begin
            // Last bit of a full word: present it and restart immediately.
            data_d  = word_in;
            mod_d   = '0;
            val_d   = 1'b1;
            sh_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            sh_d  = word_in;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Burst ended early: keep it if long enough, otherwise flag it.
          if (cnt_q >= CNT_W'(MIN_BITS)) begin
            data_d = sh_q;
            mod_d  = cnt_q[W_MOD-1:0];
            val_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          sh_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        sh_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over any input in the same cycle.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  assign bus.deser_data     = data_q;
  assign bus.deser_data_mod = mod_q;
  assign bus.deser_data_val = val_q;
  assign bus.err            = err_q;
  assign bus.deser_busy     = (state_q == COLLECT);
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: a table of single bursts, then
// hand-written back-to-back, reset and serializer-style loopback sequences.
module tb_deserializer;
  import deserializer_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic   clk;
  logic   srst;
  state_t dbg_state;

  deserializer_if bus_if ();

  deserializer dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_bad    = 0;
  logic [W_DATA-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Apply one cycle of input, then look at the outputs 1 ns after the edge.
  task automatic step(input logic v, input logic d);
    bus_if.ser_data_val = v;
    bus_if.ser_data     = d;
    @(posedge clk);
    #1;
  endtask

  // Send the n most significant bits of word, MSB first, contiguous valid.
  task automatic send_bits(input int n, input logic [W_DATA-1:0] word);
    for (int k = 0; k < n; k++) step(1'b1, word[W_DATA-1-k]);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int                n_bits;
    logic [W_DATA-1:0] word;
    logic              exp_val;
    logic [W_DATA-1:0] exp_data;
    logic [W_MOD-1:0]  exp_mod;
    logic              exp_err;
  } vec_t;

  vec_t vecs[7];

  // Watchdog: the sequences are finite, this only guards against a stuck sim.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int last_c;
    logic [W_DATA-1:0] w0, w1, mask, rnd;
    logic [W_DATA-1:0] got;
    int mods[16];
    int n;

    // Bursts, MSB-first; data/mod on an error row are the held values.
    vecs[0] = '{16, 16'hA5C3, 1'b1, 16'hA5C3, 4'd0,  1'b0};
    vecs[1] = '{5,  16'hB000, 1'b1, 16'hB000, 4'd5,  1'b0};
    vecs[2] = '{2,  16'hC000, 1'b0, 16'hB000, 4'd5,  1'b1};
    vecs[3] = '{1,  16'h8000, 1'b0, 16'hB000, 4'd5,  1'b1};
    vecs[4] = '{3,  16'h6000, 1'b1, 16'h6000, 4'd3,  1'b0};
    vecs[5] = '{15, 16'hFFFE, 1'b1, 16'hFFFE, 4'd15, 1'b0};
    vecs[6] = '{16, 16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0};

    bus_if.ser_data     = 1'b0;
    bus_if.ser_data_val = 1'b0;

    // Reset, with valid bits presented to show reset priority.
    srst = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("rst_val",   32'(bus_if.deser_data_val), 32'd0);
    check("rst_err",   32'(bus_if.err),            32'd0);
    check("rst_busy",  32'(bus_if.deser_busy),     32'd0);
    check("rst_data",  32'(bus_if.deser_data),     32'd0);
    check("rst_mod",   32'(bus_if.deser_data_mod), 32'd0);
    check("rst_state", 32'(dbg_state),             32'(IDLE));
    srst = 1'b0;
    step(1'b0, 1'b0);

    // Table-driven single bursts.
    for (int i = 0; i < 7; i++) begin
      send_bits(vecs[i].n_bits, vecs[i].word);
      if (vecs[i].n_bits < W_DATA) begin
        check($sformatf("vec%0d_busy_mid", i), 32'(bus_if.deser_busy), 32'd1);
        step(1'b0, 1'b0);
      end
      check($sformatf("vec%0d_val", i),  32'(bus_if.deser_data_val), 32'(vecs[i].exp_val));
      check($sformatf("vec%0d_data", i), 32'(bus_if.deser_data),     32'(vecs[i].exp_data));
      check($sformatf("vec%0d_mod", i),  32'(bus_if.deser_data_mod), 32'(vecs[i].exp_mod));
      check($sformatf("vec%0d_err", i),  32'(bus_if.err),            32'(vecs[i].exp_err));
      check($sformatf("vec%0d_busy", i), 32'(bus_if.deser_busy),     32'd0);
      step(1'b0, 1'b0);
      check($sformatf("vec%0d_val_drop", i), 32'(bus_if.deser_data_val), 32'd0);
      check($sformatf("vec%0d_err_drop", i), 32'(bus_if.err),            32'd0);
    end

    // Back-to-back full words with no gap.
    w0 = 16'h1234;
    w1 = 16'hFFFF;
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    pulses = 0;
    last_c = -1;
    for (int c = 0; c < 2 * W_DATA; c++) begin
      step(1'b1, (c < W_DATA) ? w0[W_DATA-1-c] : w1[2*W_DATA-1-c]);
      if (bus_if.deser_data_val) begin
        if (exp_q.size() == 0) begin
          check("b2b_extra_val", 32'(c), 32'hFFFF_FFFF);
        end else begin
          got = exp_q.pop_front();
          check($sformatf("b2b_data%0d", pulses), 32'(bus_if.deser_data), 32'(got));
          check($sformatf("b2b_mod%0d", pulses),  32'(bus_if.deser_data_mod), 32'd0);
        end
        if (pulses > 0) check("b2b_spacing", 32'(c - last_c), 32'(W_DATA));
        last_c = c;
        pulses++;
      end
    end
    step(1'b0, 1'b0);
    check("b2b_pulses",  32'(pulses),       32'd2);
    check("b2b_pending", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a burst: no val, no err, then a clean word.
    send_bits(7, 16'hDEAD);
    check("mid_rst_busy_before", 32'(bus_if.deser_busy), 32'd1);
    srst = 1'b1;
    step(1'b1, 1'b1);
    srst = 1'b0;
    check("mid_rst_val",  32'(bus_if.deser_data_val), 32'd0);
    check("mid_rst_err",  32'(bus_if.err),            32'd0);
    check("mid_rst_busy", 32'(bus_if.deser_busy),     32'd0);
    check("mid_rst_data", 32'(bus_if.deser_data),     32'd0);
    step(1'b0, 1'b0);
    check("mid_rst_val_after", 32'(bus_if.deser_data_val), 32'd0);
    check("mid_rst_err_after", 32'(bus_if.err),            32'd0);
    send_bits(W_DATA, 16'h8001);
    check("post_rst_val",  32'(bus_if.deser_data_val), 32'd1);
    check("post_rst_data", 32'(bus_if.deser_data),     32'h8001);
    check("post_rst_mod",  32'(bus_if.deser_data_mod), 32'd0);
    step(1'b0, 1'b0);

    // Loopback against a serializer-style source: mod 0 and 3..15 are
    // reconstructed, mod 1 and 2 are dropped with an error.
    mods[0] = 0;
    for (int m = 3; m < 16; m++) mods[m - 2] = m;
    mods[14] = 1;
    mods[15] = 2;
    for (int i = 0; i < 16; i++) begin
      rnd  = 16'($urandom_range(0, 16'hFFFF));
      n    = (mods[i] == 0) ? W_DATA : mods[i];
      mask = (mods[i] == 0) ? 16'hFFFF : ~(16'hFFFF >> mods[i]);
      send_bits(n, rnd);
      if (n < W_DATA) step(1'b0, 1'b0);
      if (mods[i] == 0 || mods[i] >= MIN_BITS) begin
        check($sformatf("lb_mod%0d_val", mods[i]),  32'(bus_if.deser_data_val), 32'd1);
        check($sformatf("lb_mod%0d_data", mods[i]), 32'(bus_if.deser_data),     32'(rnd & mask));
        check($sformatf("lb_mod%0d_mod", mods[i]),  32'(bus_if.deser_data_mod), 32'(mods[i]));
        check($sformatf("lb_mod%0d_err", mods[i]),  32'(bus_if.err),            32'd0);
      end else begin
        check($sformatf("lb_mod%0d_val", mods[i]), 32'(bus_if.deser_data_val), 32'd0);
        check($sformatf("lb_mod%0d_err", mods[i]), 32'(bus_if.err),            32'd1);
      end
      step(1'b0, 1'b0);
    end

    // ---------------------------------------------------------------- report
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Downstream partner of the serializer stage. It consumes the MSB-first serial stream (ser_data / ser_data_val) and rebuilds parallel words.
- A full word is W_DATA bits of contiguous valid. A burst that ends early (valid drops after k bits, MIN_BITS <= k < W_DATA) is emitted left-aligned, with its bit count on the mod output. This makes the block the inverse of the serializer's data/mod interface.
- Bursts shorter than MIN_BITS are discarded and flagged.

Parameters:
- W_DATA, 16, parallel word width
- W_MOD, $clog2(W_DATA) = 4, width of the bit-count (mod) output
- MIN_BITS, 3, smallest partial burst accepted; shorter bursts are errors

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- srst_i  in  1  synchronous reset, active-high
- ser_data_i  in  1  serial data bit, MSB of the word first
- ser_data_val_i  in  1  ser_data_i is valid this cycle
- deser_data_o  out  W_DATA  reconstructed word, left-aligned; unused LSBs are 0
- deser_data_mod_o  out  W_MOD  bit count of the word; 0 means a full W_DATA-bit word
- deser_data_val_o  out  1  one-cycle pulse: deser_data_o / deser_data_mod_o are valid
- deser_busy_o  out  1  high while a burst is partially collected
- err_o  out  1  one-cycle pulse: a burst shorter than MIN_BITS was dropped

Behaviour:
- Interface: one clock, clk_i. Reset srst_i is synchronous and active-high.
- Reset values: all outputs 0; shift register 0; bit counter 0; state IDLE.
- Internal state: shift register sh[W_DATA-1:0]; bit counter cnt of width $clog2(W_DATA+1).
- Bit placement: the k-th valid bit of a burst (k = 0..W_DATA-1) is written to sh[W_DATA-1-k]. Bits not yet written stay 0.
- IDLE state:
  - ser_data_val_i=1: store the bit, cnt=1, go to COLLECT.
  - Otherwise stay in IDLE.
- COLLECT state, ser_data_val_i=1:
  - Store the bit and increment cnt.
  - If this is the W_DATA-th bit, register the outputs: deser_data_o = full word, mod = 0, val = 1 (visible the next cycle). Clear sh and cnt, go to IDLE.
- COLLECT state, ser_data_val_i=0:
  - cnt >= MIN_BITS: emit deser_data_o = sh, mod = cnt, val = 1 (next cycle).
  - cnt < MIN_BITS: pulse err_o (next cycle), val stays 0.
  - In both cases clear sh and cnt, go to IDLE.
- Latency: exactly 1 cycle from the sampling edge of the last bit (full word), or from the edge of the first invalid cycle (partial burst), to deser_data_val_o=1.
- Back-to-back full words:
  - A bit arriving in the cycle right after a full word completes starts a new word with no gap.
  - A valid pulse every W_DATA cycles is supported.
  - Data for word N+1 is collected while word N is presented.
- Frame boundaries: two partial bursts with no invalid cycle between them cannot be separated. They are treated as one burst; the upstream stage guarantees at least one invalid cycle between partial frames.
- Output registers: deser_data_o and deser_data_mod_o hold their last values while val=0. deser_data_val_o and err_o are single-cycle pulses.
- deser_busy_o = (state == COLLECT), driven from a register, 0 in IDLE.
- srst_i mid-burst: the partial word is discarded with no val and no err pulse. The first valid bit after reset release starts a new word.
- srst_i has priority over every input in the same cycle.

Decomposition:
- Package deserializer_pkg holds:
  - typedef enum logic {IDLE, COLLECT} state_t
  - localparam CNT_W = $clog2(W_DATA+1)
  - default W_DATA, W_MOD and MIN_BITS values, shared with the serializer bench
- No sub-module: a single module with one FSM, one counter and one shift register.

Test Plan:
- 16 contiguous valid bits of 0xA5C3 -> one cycle after the 16th bit: val=1, data=0xA5C3, mod=0, err=0.
- 5 valid bits 1,0,1,1,0 then valid=0 -> next cycle: val=1, data=0xB000, mod=5; busy falls with the emission.
- 2 valid bits then gap -> err=1 for one cycle, val stays 0.
- Repeat with a 1-bit burst -> same error response.
- 32 contiguous valid bits carrying 0x1234 then 0xFFFF -> two val pulses exactly 16 cycles apart, data 0x1234 then 0xFFFF, both mod=0.
- srst_i asserted after 7 bits of a burst -> no val and no err. A following 16-bit burst of 0x8001 is received correctly.
- Loopback: serializer -> deserializer over all data_mod 0 and 3..15, with random data -> data_o equals data_i masked to mod bits, mod_o equals data_mod_i. Mod 1..2 produce no output.
